// File: rtl/axi_pkg.sv
// Shared AXI helpers for the write-data scheduler.
//   axi_burst_max_c : longest legal AXI4 INCR burst, in beats
//   clog2_f         : ceiling log2, usable in parameter expressions
//   sched_state_e   : scheduler grant state
package axi_pkg;

  localparam int axi_burst_max_c = 256;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } sched_state_e;

endpackage

// File: rtl/sched_ord_fifo.sv
// Order FIFO holding granted master indices in AW grant order.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored while full)
//   pop        : retire the head entry (ignored while empty)
//   dout       : head entry, valid whenever empty=0
//   full/empty : occupancy flags
//   level      : current occupancy, 0..DEPTH
// A pushed entry is visible at dout from the next cycle; there is no bypass.
module sched_ord_fifo
  import axi_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  localparam int PTR_W = clog2_f(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign level   = count_reg;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // The head must drive the W mux in the same cycle, so the read is combinational.
  assign dout = mem[rd_ptr_reg];

endmodule

// File: rtl/axi_wr_data_sched.sv
// Shares one AXI W channel between N_MST write masters, serving whole bursts
// in the order their AW requests were granted.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ord_valid/ready/idx : AW arbiter pushes a granted master index
//   s_w*                : per-master W channels, master i at slice i
//   m_w*                : shared W channel towards memory
//   busy                : at least one burst outstanding
//   err_len             : sticky, a burst ran past MAX_BEATS beats
//   err_idx             : sticky, an out-of-range index was pushed
module axi_wr_data_sched
  import axi_pkg::*;
#(
  parameter int N_MST        = 4,
  parameter int ID_MAX_WIDTH = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int ORD_DEPTH    = 8,
  parameter int MAX_BEATS    = axi_burst_max_c,
  localparam int IDX_W  = clog2_f(N_MST),
  localparam int STRB_W = DATA_WIDTH / 8,
  localparam int BCNT_W = clog2_f(MAX_BEATS) + 1,
  localparam int LVL_W  = clog2_f(ORD_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ord_valid,
  output logic                          ord_ready,
  input  logic [IDX_W-1:0]              ord_idx,
  input  logic [N_MST-1:0]              s_wvalid,
  output logic [N_MST-1:0]              s_wready,
  input  logic [N_MST*ID_MAX_WIDTH-1:0] s_wid,
  input  logic [N_MST*DATA_WIDTH-1:0]   s_wdata,
  input  logic [N_MST*STRB_W-1:0]       s_wstrb,
  input  logic [N_MST-1:0]              s_wlast,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  output logic [ID_MAX_WIDTH-1:0]       m_wid,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  output logic [STRB_W-1:0]             m_wstrb,
  output logic                          m_wlast,
  output logic                          busy,
  output logic                          err_len,
  output logic                          err_idx
);

  sched_state_e state_reg;
  sched_state_e state_next;

  logic [BCNT_W-1:0]       beat_cnt_reg;
  logic                    err_len_reg;
  logic                    err_idx_reg;

  logic [IDX_W-1:0]        head_idx;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [LVL_W-1:0]        fifo_level;
  logic                    idx_bad;
  logic [IDX_W-1:0]        push_din;
  logic                    push_eff;
  logic                    pop_eff;
  logic                    beat;

  logic [ID_MAX_WIDTH-1:0] wid_arr   [N_MST];
  logic [DATA_WIDTH-1:0]   wdata_arr [N_MST];
  logic [STRB_W-1:0]       wstrb_arr [N_MST];

  for (genvar gi = 0; gi < N_MST; gi++) begin : g_unpack
    assign wid_arr[gi]   = s_wid[gi*ID_MAX_WIDTH +: ID_MAX_WIDTH];
    assign wdata_arr[gi] = s_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb_arr[gi] = s_wstrb[gi*STRB_W +: STRB_W];
  end

  // Only reachable when N_MST is not a power of two; a bad index is
  // replaced by master 0 so the queue stays consistent.
  assign idx_bad   = (int'(ord_idx) >= N_MST);
  assign push_din  = idx_bad ? '0 : ord_idx;
  assign ord_ready = ~fifo_full;
  assign push_eff  = ord_valid & ord_ready;
  assign beat      = m_wvalid & m_wready;
  assign pop_eff   = beat & m_wlast;
  assign busy      = ~fifo_empty;
  assign err_len   = err_len_reg;
  assign err_idx   = err_idx_reg;

  sched_ord_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (ORD_DEPTH)
  ) u_ord_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_eff),
    .pop   (pop_eff),
    .din   (push_din),
    .dout  (head_idx),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // ACTIVE exactly when the FIFO will hold a head next cycle, so the next
  // burst starts straight after wlast without an idle cycle.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (push_eff) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (pop_eff && !push_eff && (fifo_level == LVL_W'(1))) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Zero-latency W mux; m_wvalid never looks at m_wready.
  always_comb begin
    m_wvalid = 1'b0;
    m_wid    = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    m_wlast  = 1'b0;
    s_wready = '0;
    if (state_reg == ST_ACTIVE) begin
      for (int i = 0; i < N_MST; i++) begin
        if (head_idx == IDX_W'(i)) begin
          m_wvalid    = s_wvalid[i];
          m_wid       = wid_arr[i];
          m_wdata     = wdata_arr[i];
          m_wstrb     = wstrb_arr[i];
          m_wlast     = s_wlast[i];
          s_wready[i] = m_wready;
        end
      end
    end
  end

  // The beat counter saturates so an overlong burst cannot wrap it back
  // into the legal range; the grant is still held until wlast arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_reg <= '0;
      err_len_reg  <= 1'b0;
      err_idx_reg  <= 1'b0;
    end else begin
      if (beat) begin
        if (m_wlast) begin
          beat_cnt_reg <= '0;
        end else if (beat_cnt_reg != '1) begin
          beat_cnt_reg <= beat_cnt_reg + BCNT_W'(1);
        end
        if (!m_wlast && (beat_cnt_reg == BCNT_W'(MAX_BEATS - 1))) err_len_reg <= 1'b1;
      end
      if (push_eff && idx_bad) err_idx_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_wr_data_sched.sv
// Testbench for axi_wr_data_sched: directed table, corner-case sequences and
// a randomized run against a queue-based reference model.
module tb_axi_wr_data_sched;

  localparam int N  = 4;
  localparam int IW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int OD = 8;
  localparam int MB = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            ord_valid;
  logic            ord_ready;
  logic [1:0]      ord_idx;
  logic [N-1:0]    s_wvalid, s_wready, s_wlast;
  logic [N*IW-1:0] s_wid;
  logic [N*DW-1:0] s_wdata;
  logic [N*SW-1:0] s_wstrb;
  logic            m_wvalid, m_wready, m_wlast;
  logic [IW-1:0]   m_wid;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic            busy, err_len, err_idx;

  axi_wr_data_sched #(
    .N_MST(N), .ID_MAX_WIDTH(IW), .DATA_WIDTH(DW), .ORD_DEPTH(OD), .MAX_BEATS(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_idx(ord_idx),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wid(s_wid), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wid(m_wid), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .busy(busy), .err_len(err_len), .err_idx(err_idx)
  );

  // Three-master instance: the only way an out-of-range index fits the port.
  logic         b_ord_valid, b_ord_ready;
  logic [1:0]   b_ord_idx;
  logic [2:0]   b_s_wvalid, b_s_wready, b_s_wlast;
  logic [47:0]  b_s_wid;
  logic [95:0]  b_s_wdata;
  logic [11:0]  b_s_wstrb;
  logic         b_m_wvalid, b_m_wready, b_m_wlast;
  logic [15:0]  b_m_wid;
  logic [31:0]  b_m_wdata;
  logic [3:0]   b_m_wstrb;
  logic         b_busy, b_err_len, b_err_idx;

  axi_wr_data_sched #(
    .N_MST(3), .ID_MAX_WIDTH(16), .DATA_WIDTH(32), .ORD_DEPTH(8), .MAX_BEATS(256)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ord_valid(b_ord_valid), .ord_ready(b_ord_ready), .ord_idx(b_ord_idx),
    .s_wvalid(b_s_wvalid), .s_wready(b_s_wready), .s_wid(b_s_wid), .s_wdata(b_s_wdata),
    .s_wstrb(b_s_wstrb), .s_wlast(b_s_wlast),
    .m_wvalid(b_m_wvalid), .m_wready(b_m_wready), .m_wid(b_m_wid), .m_wdata(b_m_wdata),
    .m_wstrb(b_m_wstrb), .m_wlast(b_m_wlast),
    .busy(b_busy), .err_len(b_err_len), .err_idx(b_err_idx)
  );

  int errors = 0;
  int checks = 0;
  int mb[N];    // beats already sent by each master in its current burst
  int blen[N];  // burst length each master uses in directed tests

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i, input int k);
    return {8'hD0, 8'(i), 16'(k)};
  endfunction

  // Drive one cycle just after the edge, then let the mux settle for sampling.
  task automatic drive(input bit ov, input bit [1:0] oi, input bit [3:0] sv, input bit mr);
    @(posedge clk);
    #1;
    ord_valid = ov;
    ord_idx   = oi;
    s_wvalid  = sv;
    m_wready  = mr;
    for (int i = 0; i < N; i++) begin
      s_wlast[i]            = (mb[i] == blen[i] - 1);
      s_wdata[i*DW +: DW]   = pat(i, mb[i]);
    end
    #4;
  endtask

  task automatic account();
    for (int i = 0; i < N; i++) begin
      if (s_wvalid[i] && s_wready[i]) mb[i] = s_wlast[i] ? 0 : mb[i] + 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    ord_valid = 1'b0;
    s_wvalid  = '0;
    m_wready  = 1'b0;
    for (int i = 0; i < N; i++) mb[i] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit       ov;
    bit [1:0] oi;
    bit [3:0] sv;
    bit       e_mv;
    bit [3:0] e_sr;
    bit       e_ml;
    bit       e_busy;
    bit       e_ordy;
    int       e_head;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int nbeats;
    int ids[$];
    int cyc_of[$];
    int done;
    int q[$];
    int bc;
    bit elen;
    int h;
    int blen_r;
    bit push_ok;
    bit exp_mv;
    logic [3:0] exp_sr;

    ord_valid   = 1'b0;
    ord_idx     = '0;
    s_wvalid    = '0;
    s_wlast     = '0;
    m_wready    = 1'b0;
    s_wdata     = '0;
    for (int i = 0; i < N; i++) begin
      s_wid[i*IW +: IW]   = 16'h100 + 16'(i);
      s_wstrb[i*SW +: SW] = 4'(1 << i);
      mb[i]   = 0;
      blen[i] = 1;
    end
    b_ord_valid = 1'b0;
    b_ord_idx   = '0;
    b_s_wvalid  = '0;
    b_s_wlast   = 3'b111;
    b_s_wid     = '0;
    b_s_wdata   = '0;
    b_s_wstrb   = '0;
    b_m_wready  = 1'b0;

    // ---- reset state ----
    @(posedge clk);
    #2;
    chk("rst_m_wvalid", 64'(m_wvalid), 64'(0));
    chk("rst_s_wready", 64'(s_wready), 64'(0));
    chk("rst_ord_ready", 64'(ord_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err_len", 64'(err_len), 64'(0));
    chk("rst_err_idx", 64'(err_idx), 64'(0));
    chk("rst_b_err_idx", 64'(b_err_idx), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // ---- single burst, table driven ----
    tbl[0] = '{1'b1, 2'd2, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, -1};
    tbl[1] = '{1'b0, 2'd0, 4'h4, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 2};
    tbl[2] = '{1'b0, 2'd0, 4'h4, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 2};
    tbl[3] = '{1'b0, 2'd0, 4'h4, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 2};
    tbl[4] = '{1'b0, 2'd0, 4'h4, 1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 2};
    tbl[5] = '{1'b0, 2'd0, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, -1};
    blen[2] = 4;
    nbeats  = 0;
    for (int v = 0; v < 6; v++) begin
      drive(tbl[v].ov, tbl[v].oi, tbl[v].sv, 1'b1);
      chk("sb_m_wvalid", 64'(m_wvalid), 64'(tbl[v].e_mv));
      chk("sb_s_wready", 64'(s_wready), 64'(tbl[v].e_sr));
      chk("sb_m_wlast", 64'(m_wlast), 64'(tbl[v].e_ml));
      chk("sb_busy", 64'(busy), 64'(tbl[v].e_busy));
      chk("sb_ord_ready", 64'(ord_ready), 64'(tbl[v].e_ordy));
      if (tbl[v].e_head >= 0) begin
        chk("sb_m_wdata", 64'(m_wdata), 64'(pat(tbl[v].e_head, mb[tbl[v].e_head])));
        chk("sb_m_wid", 64'(m_wid), 64'(16'h100 + 16'(tbl[v].e_head)));
      end else begin
        chk("sb_m_wdata_idle", 64'(m_wdata), 64'(0));
      end
      if (m_wvalid && m_wready) nbeats++;
      $display("vec %0d: m_wvalid=%0b s_wready=%b m_wlast=%0b busy=%0b data=%h",
               v, m_wvalid, s_wready, m_wlast, busy, m_wdata);
      account();
    end
    chk("sb_beat_count", 64'(nbeats), 64'(4));

    // ---- ordering: push 3,0,3, all masters valid, 2-beat bursts ----
    do_reset();
    for (int i = 0; i < N; i++) blen[i] = 2;
    for (int c = 0; c < 9; c++) begin
      drive(c < 3, (c == 1) ? 2'd0 : 2'd3, 4'hF, 1'b1);
      if (m_wvalid && m_wready) begin
        ids.push_back(int'(m_wid) - 256);
        cyc_of.push_back(c);
        $display("order beat: cycle %0d master %0d last=%0b", c, int'(m_wid) - 256, m_wlast);
      end
      account();
    end
    chk("ord_beats", 64'(ids.size()), 64'(6));
    if (ids.size() == 6) begin
      chk("ord_m0", 64'(ids[0]), 64'(3));
      chk("ord_m1", 64'(ids[1]), 64'(3));
      chk("ord_m2", 64'(ids[2]), 64'(0));
      chk("ord_m3", 64'(ids[3]), 64'(0));
      chk("ord_m4", 64'(ids[4]), 64'(3));
      chk("ord_m5", 64'(ids[5]), 64'(3));
      for (int k = 0; k < 6; k++) chk("ord_no_gap", 64'(cyc_of[k]), 64'(k + 1));
    end

    // ---- backpressure mid-burst ----
    do_reset();
    blen[1] = 4;
    drive(1'b1, 2'd1, 4'h0, 1'b1);
    account();
    drive(1'b0, 2'd0, 4'h2, 1'b1);
    account();
    drive(1'b0, 2'd0, 4'h2, 1'b1);
    account();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 2'd0, 4'h2, 1'b0);
      chk("bp_m_wvalid", 64'(m_wvalid), 64'(1));
      chk("bp_m_wdata", 64'(m_wdata), 64'(32'hD001_0002));
      chk("bp_s_wready", 64'(s_wready), 64'(0));
      chk("bp_busy", 64'(busy), 64'(1));
      account();
    end
    $display("backpressure: stalled 5 cycles, data=%h", m_wdata);
    drive(1'b0, 2'd0, 4'h2, 1'b1);
    chk("bp_beat3_last", 64'(m_wlast), 64'(0));
    chk("bp_beat3_data", 64'(m_wdata), 64'(32'hD001_0002));
    account();
    drive(1'b0, 2'd0, 4'h2, 1'b1);
    chk("bp_beat4_last", 64'(m_wlast), 64'(1));
    chk("bp_beat4_ready", 64'(s_wready), 64'(4'h2));
    account();
    drive(1'b0, 2'd0, 4'h2, 1'b1);
    chk("bp_done_busy", 64'(busy), 64'(0));
    chk("bp_done_wvalid", 64'(m_wvalid), 64'(0));

    // ---- full FIFO ----
    do_reset();
    for (int i = 0; i < N; i++) blen[i] = 1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 2'(k % 4), 4'h0, 1'b1);
      chk("full_fill_ready", 64'(ord_ready), 64'(1));
    end
    drive(1'b0, 2'd0, 4'h0, 1'b1);
    chk("full_ord_ready", 64'(ord_ready), 64'(0));
    chk("full_busy", 64'(busy), 64'(1));
    chk("full_head", 64'(m_wid), 64'(16'h100));
    drive(1'b1, 2'd2, 4'h1, 1'b1);
    chk("full_pop_ready", 64'(ord_ready), 64'(0));
    chk("full_pop_last", 64'(m_wlast), 64'(1));
    account();
    drive(1'b1, 2'd2, 4'h2, 1'b1);
    chk("full_pp_ready", 64'(ord_ready), 64'(1));
    chk("full_pp_head", 64'(m_wid), 64'(16'h101));
    account();
    drive(1'b0, 2'd0, 4'h0, 1'b1);
    chk("full_pp_keep", 64'(ord_ready), 64'(1));
    chk("full_pp_next", 64'(m_wid), 64'(16'h102));
    drive(1'b1, 2'd3, 4'h0, 1'b1);
    drive(1'b0, 2'd0, 4'h0, 1'b1);
    chk("full_refill", 64'(ord_ready), 64'(0));
    $display("full fifo: ord_ready=%0b busy=%0b", ord_ready, busy);

    // ---- overlong burst ----
    do_reset();
    blen[0] = 258;
    drive(1'b1, 2'd0, 4'h0, 1'b1);
    done = 0;
    for (int c = 0; c < 258; c++) begin
      drive(1'b0, 2'd0, 4'h1, 1'b1);
      chk("len_err_len", 64'(err_len), 64'(done >= 256));
      if (done == 256) chk("len_grant_held", 64'(m_wvalid), 64'(1));
      if (m_wvalid && m_wready) done++;
      account();
    end
    drive(1'b0, 2'd0, 4'h0, 1'b1);
    chk("len_beats", 64'(done), 64'(258));
    chk("len_sticky", 64'(err_len), 64'(1));
    chk("len_busy", 64'(busy), 64'(0));
    $display("overlong burst: %0d beats err_len=%0b", done, err_len);

    // ---- bad index on the three-master instance ----
    @(posedge clk);
    #1;
    b_ord_valid = 1'b1;
    b_ord_idx   = 2'd3;
    #4;
    chk("idx_before", 64'(b_err_idx), 64'(0));
    @(posedge clk);
    #1;
    b_ord_valid = 1'b0;
    b_s_wvalid  = 3'b001;
    b_m_wready  = 1'b1;
    #4;
    chk("idx_err", 64'(b_err_idx), 64'(1));
    chk("idx_busy", 64'(b_busy), 64'(1));
    chk("idx_head0_valid", 64'(b_m_wvalid), 64'(1));
    chk("idx_head0_ready", 64'(b_s_wready), 64'(3'b001));
    chk("idx_main_clean", 64'(err_idx), 64'(0));
    @(posedge clk);
    #1;
    b_s_wvalid = '0;
    #4;
    chk("idx_drained", 64'(b_busy), 64'(0));
    chk("idx_sticky", 64'(b_err_idx), 64'(1));
    $display("bad index: err_idx=%0b", b_err_idx);

    // ---- reset mid-burst ----
    do_reset();
    blen[1] = 4;
    drive(1'b1, 2'd1, 4'h0, 1'b1);
    drive(1'b0, 2'd0, 4'h2, 1'b1);
    account();
    drive(1'b0, 2'd0, 4'h2, 1'b1);
    account();
    @(posedge clk);
    #1;
    chk("mid_active", 64'(m_wvalid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_m_wvalid", 64'(m_wvalid), 64'(0));
    chk("mid_s_wready", 64'(s_wready), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_ord_ready", 64'(ord_ready), 64'(1));
    chk("mid_err_len", 64'(err_len), 64'(0));
    chk("mid_b_err_idx", 64'(b_err_idx), 64'(0));
    $display("reset mid-burst: m_wvalid=%0b busy=%0b", m_wvalid, busy);
    do_reset();

    // ---- randomized run against a queue model ----
    bc     = 0;
    elen   = 1'b0;
    blen_r = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      ord_valid = ($urandom_range(2) == 0);
      ord_idx   = 2'($urandom_range(3));
      s_wvalid  = 4'($urandom);
      m_wready  = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) s_wlast[i] = ($urandom_range(3) == 0);
      s_wid   = {$urandom, $urandom};
      s_wdata = {$urandom, $urandom, $urandom, $urandom};
      s_wstrb = 16'($urandom);
      #4;
      h      = (q.size() > 0) ? q[0] : -1;
      exp_mv = (h >= 0) && s_wvalid[h];
      exp_sr = ((h >= 0) && m_wready) ? 4'(1 << h) : 4'h0;
      chk("rnd_m_wvalid", 64'(m_wvalid), 64'(exp_mv));
      chk("rnd_s_wready", 64'(s_wready), 64'(exp_sr));
      chk("rnd_ord_ready", 64'(ord_ready), 64'(q.size() < OD));
      chk("rnd_busy", 64'(busy), 64'(q.size() > 0));
      if (h >= 0) begin
        chk("rnd_m_wdata", 64'(m_wdata), 64'(s_wdata[h*DW +: DW]));
        chk("rnd_m_wid", 64'(m_wid), 64'(s_wid[h*IW +: IW]));
        chk("rnd_m_wstrb", 64'(m_wstrb), 64'(s_wstrb[h*SW +: SW]));
        chk("rnd_m_wlast", 64'(m_wlast), 64'(s_wlast[h]));
      end else begin
        chk("rnd_idle_data", 64'(m_wdata), 64'(0));
      end
      push_ok = ord_valid && (q.size() < OD);
      if (exp_mv && m_wready) begin
        blen_r++;
        if (!s_wlast[h] && bc == MB - 1) elen = 1'b1;
        if (s_wlast[h]) begin
          $display("rnd burst: master %0d beats=%0d cycle=%0d", h, blen_r, c);
          void'(q.pop_front());
          bc     = 0;
          blen_r = 0;
        end else begin
          bc++;
        end
      end
      if (push_ok) q.push_back(int'(ord_idx));
    end
    chk("rnd_err_len", 64'(err_len), 64'(elen));
    chk("rnd_err_idx", 64'(err_idx), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
